store_sequence_checker: RTL and testbench

//  Synthesizable self-check monitor for the MIPS core's data-memory write port.

---
 rtl/store_sequence_checker.sv | 102 ++++++++++
 tb/tb_store_sequence_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/store_sequence_checker.sv
// store_sequence_checker: watches the core's data-memory write port and checks
// that an ordered list of expected stores appears, with an optional data
// compare, an address mask and a watchdog. The first failing store is captured
// so it can be read out for debug.
module store_sequence_checker #(
  parameter int                           WIDTH      = 32,
  parameter int                           NUM_CHECKS = 2,
  parameter logic [NUM_CHECKS*WIDTH-1:0]  EXP_ADDR   = '0,
  parameter logic [NUM_CHECKS*WIDTH-1:0]  EXP_DATA   = '0,
  parameter bit                           CHECK_DATA = 1'b1,
  parameter logic [WIDTH-1:0]             ADDR_MASK  = '1,
  parameter int                           TIMEOUT    = 1024,
  localparam int                          CW         = $clog2(NUM_CHECKS+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CW-1:0]    match_count,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  // The timer stops at TIMEOUT-1, so this width can never wrap.
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

  state_t           state;
  logic [CW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] exp_a, exp_d;
  logic             last, hit;

  // Pick the expected entry for the current index; idx equals NUM_CHECKS
  // only in PASS, where the selection is unused.
  always_comb begin
    exp_a = '0;
    exp_d = '0;
    last  = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (idx == CW'(i)) begin
        exp_a = EXP_ADDR[i*WIDTH +: WIDTH];
        exp_d = EXP_DATA[i*WIDTH +: WIDTH];
        last  = (i == NUM_CHECKS-1);
      end
    end
    // Case equality: any X/Z on a compared bit makes the store a mismatch.
    hit = ((dataadr & ADDR_MASK) === (exp_a & ADDR_MASK)) &&
          (!CHECK_DATA || (writedata === exp_d));
  end

  assign match_count = idx;

  // Checker FSM: stores advance or fail the sequence, idle edges feed the
  // watchdog; terminal states freeze everything until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      idx       <= '0;
      timer     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state == S_RUN) begin
      if (memwrite) begin
        // A store always wins over a watchdog expiring on the same edge.
        if (hit) begin
          idx   <= idx + 1'b1;
          timer <= '0;
          if (last) begin
            state <= S_PASS;
            pass  <= 1'b1;
            done  <= 1'b1;
          end
        end else begin
          state     <= S_FAIL;
          fail      <= 1'b1;
          done      <= 1'b1;
          fail_addr <= dataadr;
          fail_data <= writedata;
        end
      end else begin
        timer <= timer + 1'b1;
        if (timer == TW'(TIMEOUT-2)) begin
          state   <= S_TMO;
          timeout <= 1'b1;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_sequence_checker.sv
// Bench for store_sequence_checker: three instances (full compare, address
// only, masked address) share one stimulus stream and are checked each cycle
// against a transaction-level model of the expected-store list.
module tb_store_sequence_checker;

  localparam logic [31:0] A0 = 32'h0000_0054;
  localparam logic [31:0] A1 = 32'hFFFF_8053;
  localparam int          TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;

  logic [2:0]  done, pass, fail, tmo;
  logic [1:0]  mc [3];
  logic [31:0] fa [3];
  logic [31:0] fd [3];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  store_sequence_checker #(.NUM_CHECKS(2), .EXP_ADDR({A1, A0}), .EXP_DATA({32'd7, 32'd7}),
    .CHECK_DATA(1'b1), .ADDR_MASK(32'hFFFF_FFFF), .TIMEOUT(TMO)) u_full (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[0]), .pass(pass[0]), .fail(fail[0]), .timeout(tmo[0]),
    .match_count(mc[0]), .fail_addr(fa[0]), .fail_data(fd[0]));

  store_sequence_checker #(.NUM_CHECKS(2), .EXP_ADDR({A1, A0}), .EXP_DATA({32'd7, 32'd7}),
    .CHECK_DATA(1'b0), .ADDR_MASK(32'hFFFF_FFFF), .TIMEOUT(TMO)) u_nodata (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[1]), .pass(pass[1]), .fail(fail[1]), .timeout(tmo[1]),
    .match_count(mc[1]), .fail_addr(fa[1]), .fail_data(fd[1]));

  store_sequence_checker #(.NUM_CHECKS(2), .EXP_ADDR({A1, A0}), .EXP_DATA({32'd7, 32'd7}),
    .CHECK_DATA(1'b1), .ADDR_MASK(32'hFFFF_FFFC), .TIMEOUT(TMO)) u_mask (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done[2]), .pass(pass[2]), .fail(fail[2]), .timeout(tmo[2]),
    .match_count(mc[2]), .fail_addr(fa[2]), .fail_data(fd[2]));

  // Reference model: per instance, the outcome so far (running / passed /
  // failed / timed out), how many list entries have been seen, idle edges
  // since the last accepted store, and the captured failing store.
  typedef enum int {M_RUN, M_PASS, M_FAIL, M_TMO} mres_t;
  mres_t       m_res [3];
  int          m_seen [3];
  int          m_idle [3];
  logic [31:0] m_fa [3];
  logic [31:0] m_fd [3];
  logic [31:0] exp_list_a [2];
  logic [31:0] exp_list_d [2];
  bit          cfg_data [3];
  logic [31:0] cfg_mask [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_res[k] = M_RUN; m_seen[k] = 0; m_idle[k] = 0; m_fa[k] = '0; m_fd[k] = '0;
    end
  endtask

  // One clock edge of the expected-store list semantics.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (m_res[k] != M_RUN) continue;
      if (memwrite) begin
        if (((dataadr & cfg_mask[k]) == (exp_list_a[m_seen[k]] & cfg_mask[k])) &&
            (!cfg_data[k] || writedata == exp_list_d[m_seen[k]])) begin
          m_seen[k]++;
          m_idle[k] = 0;
          if (m_seen[k] == 2) m_res[k] = M_PASS;
        end else begin
          m_res[k] = M_FAIL; m_fa[k] = dataadr; m_fd[k] = writedata;
        end
      end else begin
        m_idle[k]++;
        if (m_idle[k] == TMO-1) m_res[k] = M_TMO;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.u%0d.done", tag, k), 32'(done[k]), 32'(m_res[k] != M_RUN));
      chk($sformatf("%s.u%0d.pass", tag, k), 32'(pass[k]), 32'(m_res[k] == M_PASS));
      chk($sformatf("%s.u%0d.fail", tag, k), 32'(fail[k]), 32'(m_res[k] == M_FAIL));
      chk($sformatf("%s.u%0d.tmo", tag, k), 32'(tmo[k]), 32'(m_res[k] == M_TMO));
      chk($sformatf("%s.u%0d.mc", tag, k), 32'(mc[k]), 32'(m_seen[k]));
      chk($sformatf("%s.u%0d.fa", tag, k), fa[k], m_fa[k]);
      chk($sformatf("%s.u%0d.fd", tag, k), fd[k], m_fd[k]);
    end
  endtask

  task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite = mw; dataadr = a; writedata = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
  endtask

  // Assert reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    exp_list_a[0] = A0; exp_list_a[1] = A1;
    exp_list_d[0] = 32'd7; exp_list_d[1] = 32'd7;
    cfg_data[0] = 1'b1; cfg_mask[0] = 32'hFFFF_FFFF;
    cfg_data[1] = 1'b0; cfg_mask[1] = 32'hFFFF_FFFF;
    cfg_data[2] = 1'b1; cfg_mask[2] = 32'hFFFF_FFFC;
    model_reset();
    do_reset();

    // 1: in-order pass, then later stores must not disturb anything
    cyc(1'b1, A0, 7); cyc(1'b1, A1, 7);
    chk("t1_pass", 32'(pass[0]), 1); chk("t1_done", 32'(done[0]), 1); chk("t1_mc", 32'(mc[0]), 2);
    cyc(1'b1, 32'h50, 1); cyc(1'b1, A0, 7); idle(20);
    chk("t1_hold_pass", 32'(pass[0]), 1); chk("t1_hold_tmo", 32'(tmo[0]), 0);

    // 2: second store to the wrong address
    do_reset();
    cyc(1'b1, A0, 7); cyc(1'b1, 32'h50, 7);
    chk("t2_fail", 32'(fail[0]), 1); chk("t2_fa", fa[0], 32'h50);
    chk("t2_fd", fd[0], 7); chk("t2_mc", 32'(mc[0]), 1);

    // 3: wrong data passes only when data is not compared
    do_reset();
    cyc(1'b1, A0, 3); cyc(1'b1, A1, 9);
    chk("t3_nodata_pass", 32'(pass[1]), 1); chk("t3_full_fail", 32'(fail[0]), 1);
    chk("t3_full_fd", fd[0], 3); chk("t3_full_mc", 32'(mc[0]), 0);

    // 4: watchdog expires on the 15th idle edge; a store there wins instead
    do_reset();
    idle(14);
    chk("t4_no_tmo_yet", 32'(tmo[0]), 0);
    idle(1);
    chk("t4_tmo", 32'(tmo[0]), 1); chk("t4_tmo_done", 32'(done[0]), 1);
    do_reset();
    idle(14); cyc(1'b1, A0, 7);
    chk("t4_store_wins_tmo", 32'(tmo[0]), 0); chk("t4_store_wins_mc", 32'(mc[0]), 1);
    idle(14);
    chk("t4_timer_restarted", 32'(tmo[0]), 0);
    idle(1);
    chk("t4_tmo_after_store", 32'(tmo[0]), 1);

    // 5: async reset after the first match, then a full pass again
    do_reset();
    cyc(1'b1, A0, 7);
    chk("t5_mc_before", 32'(mc[0]), 1);
    do_reset();
    chk("t5_mc_cleared", 32'(mc[0]), 0);
    cyc(1'b1, A0, 7); cyc(1'b1, A1, 7);
    chk("t5_repass", 32'(pass[0]), 1);

    // 6: masked address bits are ignored
    do_reset();
    cyc(1'b1, 32'h56, 7);
    chk("t6_mask_mc", 32'(mc[2]), 1); chk("t6_full_fail", 32'(fail[0]), 1);

    // Random sessions: mixes of right/wrong stores and idle gaps
    for (int r = 0; r < 40; r++) begin
      int len, busy;
      do_reset();
      len  = $urandom_range(5, 45);
      busy = $urandom_range(0, 1);
      for (int c = 0; c < len; c++) begin
        logic        mw;
        logic [31:0] a, d;
        mw = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 5))
          0, 1, 2: a = (m_seen[0] == 1) ? A1 : A0;
          3:       a = $urandom_range(0, 1) ? A0 : A1;
          4:       a = (A0 | 32'($urandom_range(0, 3)));
          default: a = $urandom;
        endcase
        d = ($urandom_range(0, 3) != 0) ? 32'd7 : 32'($urandom_range(0, 15));
        cyc(mw, a, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  // Hard stop so a stalled run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got running want finished");
    $fatal(1);
  end

endmodule
